cla_share_arbiter: RTL
======================

// Module: cla_share_arbiter
// PURPOSE
//  Shares one 32-bit CLA adder instance between NREQ requesters.
//  Each requester offers (a, b, cin) on a valid/ready handshake.
//  A round-robin arbiter issues at most one add per cycle into the CLA.
//  The result is captured in a single registered response slot with valid/ready backpressure.
//  Sits between ALU-side clients (address gen, accumulator, PC increment) and the CLA datapath.
// PARAMETERS
//  NREQ   4   number of requesters, legal range 2..8
//  CNT_W  16  width of the completed-operation counter
//  ID_W   $clog2(NREQ)  derived, not overridable; width of resp_id
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         reset, asynchronous, active-low
//  req_valid  in   NREQ      requester i offers an operation
//  req_ready  out  NREQ      one-hot grant; handshake on valid&ready
//  req_a      in   NREQ*32   operand A; requester i at [32*i+31:32*i]
//  req_b      in   NREQ*32   operand B, same packing
//  req_cin    in   NREQ      carry-in per requester
//  resp_valid out  1         response slot holds a result
//  resp_ready in   1         consumer accepts the response this cycle
//  resp_id    out  ID_W      index of the requester that owns the result
//  resp_sum   out  32        A+B+cin, low 32 bits
//  resp_cout  out  1         carry out of bit 31
//  op_count   out  CNT_W     completed (consumed) responses, wraps
// BEHAVIOUR
//  Reset (async on rst_n=0): resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, op_count=0, rr_ptr=0.
//    req_ready=0 while rst_n=0.
//  Slot states (tracked by resp_valid):
//    EMPTY: no result held; a grant is allowed.
//    FULL: a result is held.
//      resp_ready=1 drains the slot; a grant in the same cycle refills it (FULL->FULL).
//      resp_ready=0 holds all resp_* outputs stable and issues no grant.
//  can_issue = !resp_valid | resp_ready.
//  Grant: if can_issue, scan rr_ptr, rr_ptr+1, ... mod NREQ and take the first i with req_valid[i].
//    req_ready = onehot(i); otherwise req_ready = 0.
//    req_ready is combinational from req_valid, resp_valid, resp_ready and rr_ptr; it has no combinational path from req_a, req_b or req_cin.
//  On grant to i: the CLA is fed requester i's (a, b, cin) combinationally.
//    Next edge: resp_sum, resp_cout and resp_id=i load; resp_valid=1; rr_ptr=(i+1) mod NREQ.
//    Latency: one cycle from handshake to resp_valid.
//  No grant: rr_ptr unchanged.
//  Requesters hold valid and payload stable until handshake; withdrawing early is a protocol error (bench asserts).
//  op_count increments on each resp_valid&resp_ready and wraps 2^CNT_W-1 -> 0.
//  Sustained throughput is one op per cycle when resp_ready is held high.
//  Reset mid-operation: the slot content is discarded, rr_ptr returns to 0, and the in-flight grant is lost.
// CONFIGURATION
//  CLA_SHARE_OVF_EN defined:
//    Adds port resp_ovf (out, 1): signed overflow, registered with resp_sum.
//    resp_ovf = (a[31]==b[31]) & (sum[31]!=a[31]); reset 0.
//  CLA_SHARE_OVF_EN undefined:
//    Port absent and no overflow logic; all other behaviour is identical.
// TESTING
//  Reset: rst_n=0 mid-stream -> all outputs 0 immediately; after release, first grant goes to req 0.
//  Single add: req 2 a=0xFFFF_FFFF, b=0x1, cin=0, resp_ready=1 -> next cycle resp_valid=1, sum=0, cout=1, id=2.
//  Round robin: all 4 valid every cycle, resp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; op_count counts 1..5.
//  Backpressure: slot FULL with resp_ready=0 for 3 cycles -> req_ready=0 and resp_* stable; resp_ready=1 -> drain and refill in the same cycle.
//  Carry-in: a=0x7FFF_FFFF, b=0, cin=1 -> sum=0x8000_0000, cout=0, and resp_ovf=1 when CLA_SHARE_OVF_EN is defined.
//  Counter wrap: CNT_W=4, 17 consumed responses -> op_count=1.

Source files
------------

// File: rtl/cla_share_arbiter.sv
// cla_share_arbiter: round-robin sharing of one 32-bit CLA adder between NREQ requesters, one registered response slot.
// Optional feature: define CLA_SHARE_OVF_EN to add the registered signed-overflow output resp_ovf.
module cla_share_arbiter #(
  parameter int NREQ = 4,
  parameter int CNT_W = 16,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ID_W-1:0]   resp_id,
  output logic [31:0]       resp_sum,
  output logic              resp_cout,
  output logic [CNT_W-1:0]  op_count
`ifdef CLA_SHARE_OVF_EN
  ,
  output logic              resp_ovf
`endif
);
  logic            valid_q, cout_q, gnt_vld, cin_sel, cout, ovf;
  logic [ID_W-1:0] id_q, rr_q, rr_d, gnt_idx, idx;
  logic [31:0]     sum_q, a_sel, b_sel, g, p, g_l, p_l, sum;
  logic [32:0]     c;
  logic [CNT_W-1:0] cnt_q;
  // first valid requester at or after rr_q wins when the slot can accept a result
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx = '0;
    if (rst_n && (!valid_q || resp_ready))
      for (int j = NREQ - 1; j >= 0; j--) begin
        idx = ID_W'((int'(rr_q) + j) % NREQ);
        if (req_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx;
        end
      end
    req_ready = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
    rr_d = gnt_vld ? ((gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1) : rr_q;
  end
  assign a_sel   = req_a[32*gnt_idx +: 32];
  assign b_sel   = req_b[32*gnt_idx +: 32];
  assign cin_sel = req_cin[gnt_idx];
  // Kogge-Stone carry lookahead; cin is folded into bit 0's generate so every prefix is a full carry
  always_comb begin
    g = a_sel & b_sel;
    p = a_sel ^ b_sel;
    g_l = g;
    g_l[0] = g[0] | (p[0] & cin_sel);
    p_l = p;
    for (int k = 0; k < 5; k++) begin
      g_l = g_l | (p_l & (g_l << (1 << k)));
      p_l = p_l & (p_l << (1 << k));
    end
    c = {g_l, cin_sel};
    sum = p ^ c[31:0];
    cout = c[32];
    ovf = (a_sel[31] == b_sel[31]) && (sum[31] != a_sel[31]);
  end
`ifdef CLA_SHARE_OVF_EN
  logic ovf_q;
  // overflow flag travels with the sum it describes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else if (gnt_vld) ovf_q <= ovf;
  assign resp_ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif
  // response slot: a grant refills it, a consume without a grant empties it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      id_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      cnt_q <= '0;
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
      if (valid_q && resp_ready) cnt_q <= cnt_q + 1'b1;
      if (gnt_vld) begin
        valid_q <= 1'b1;
        id_q <= gnt_idx;
        sum_q <= sum;
        cout_q <= cout;
      end else if (resp_ready) valid_q <= 1'b0;
    end
  assign resp_valid = valid_q;
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign resp_cout  = cout_q;
  assign op_count   = cnt_q;
endmodule
